// File: rtl/bam_mult_scheduler_if.sv
// Request/response bundle between accelerator lanes and the shared
// broken-array multiplier scheduler. Lanes use the master view; the
// scheduler uses the slave view.
interface bam_mult_scheduler_if #(
  parameter int N_REQ = 2,
  parameter int W     = 8,
  parameter int HW    = 4,
  parameter int VW    = 5
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*W-1:0]  req_a;
  logic [N_REQ*W-1:0]  req_b;
  logic [N_REQ*HW-1:0] req_h;
  logic [N_REQ*VW-1:0] req_v;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_prod;

  modport master (
    output req_valid, req_a, req_b, req_h, req_v, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, req_h, req_v, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/bam_mult_scheduler.sv
// Round-robin scheduler sharing one runtime-configurable broken-array
// multiplier between N_REQ requesters. Each request carries its own
// horizontal (h) and vertical (v) break levels; the product is formed
// combinationally and captured in a single-entry valid/ready output stage.
module bam_mult_scheduler #(
  parameter int N_REQ = 2,
  parameter int W     = 8,
  parameter int HW    = 4,
  parameter int VW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bam_mult_scheduler_if.slave bus,
  output logic [CNT_W-1:0] op_count
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = 2 * W;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic           slot_free;
  logic           accept;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [HW-1:0]  sel_h;
  logic [VW-1:0]  sel_v;
  logic [PW-1:0]  prod;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = (32'(ptr) + off) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign slot_free = !bus.rsp_valid || bus.rsp_ready;
  assign accept    = slot_free && found;
  assign ptr_nxt   = (32'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;

  // One-hot accept towards the granted requester when the output slot frees up.
  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  // Operand and break-level mux from the granted requester.
  always_comb begin
    int unsigned gi;
    gi    = 32'(grant);
    sel_a = bus.req_a[gi*W +: W];
    sel_b = bus.req_b[gi*W +: W];
    sel_h = bus.req_h[gi*HW +: HW];
    sel_v = bus.req_v[gi*VW +: VW];
  end

  // Broken-array product: keep partial-product bit a[i]&b[j] only in rows
  // j >= h and columns i+j >= v; surviving bits are summed exactly.
  always_comb begin
    prod = '0;
    for (int unsigned i = 0; i < W; i++) begin
      for (int unsigned j = 0; j < W; j++) begin
        if (sel_a[i] && sel_b[j] && (j >= 32'(sel_h)) && ((i + j) >= 32'(sel_v)))
          prod = prod + (PW'(1) << (i + j));
      end
    end
  end

  // Output register and RR pointer; reload on accept, drain on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_prod  <= '0;
      ptr           <= '0;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= grant;
      bus.rsp_prod  <= prod;
      ptr           <= ptr_nxt;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

  // Saturating count of consumed responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (bus.rsp_valid && bus.rsp_ready && (op_count != '1))
      op_count <= op_count + 1'b1;
  end
endmodule

// File: tb/tb_bam_mult_scheduler.sv
// Self-checking bench for bam_mult_scheduler: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// behavioural model of arbitration, handshake and product rule.
module tb_bam_mult_scheduler;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int HW = 4;
  localparam int VW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_count;
  logic [3:0]  op_count_s;

  always #5 clk = ~clk;

  bam_mult_scheduler_if #(.N_REQ(N), .W(W), .HW(HW), .VW(VW)) bus ();
  bam_mult_scheduler_if #(.N_REQ(N), .W(W), .HW(HW), .VW(VW)) bus_s ();

  bam_mult_scheduler #(.N_REQ(N), .W(W), .HW(HW), .VW(VW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .op_count(op_count)
  );

  bam_mult_scheduler #(.N_REQ(N), .W(W), .HW(HW), .VW(VW), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .op_count(op_count_s)
  );

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  h;
    logic [4:0]  v;
    logic [15:0] exp;
  } vec_t;

  vec_t tv[9];

  int          vectors = 0;
  int          miscompares = 0;
  bit          m_valid;
  logic [15:0] m_prod;
  int          m_id;
  int          m_ptr;
  int          m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Rows j >= h of the partial-product array, each masked to columns >= v.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input int h, input int v);
    longint unsigned acc;
    longint unsigned mask;
    acc  = 0;
    mask = ~((64'd1 << v) - 64'd1);
    for (int j = h; j < W; j++)
      if (b[j]) acc += ((64'(a) << j) & mask);
    return 16'(acc);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_prod  = '0;
    m_id    = 0;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic set_req(input int k, input logic vld, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] h, input logic [4:0] v);
    bus.req_valid[k]       = vld;
    bus.req_a[k*W +: W]    = a;
    bus.req_b[k*W +: W]    = b;
    bus.req_h[k*HW +: HW]  = h;
    bus.req_v[k*VW +: VW]  = v;
  endtask

  // One clock: compare all outputs to the model at negedge, advance model after posedge.
  task automatic step();
    int          g;
    int          k;
    bit          found;
    bit          slot;
    logic [1:0]  exp_rdy;
    bit          n_valid;
    logic [15:0] n_prod;
    int          n_id;
    int          n_ptr;
    int          n_cnt;
    @(negedge clk);
    slot  = !m_valid || bus.rsp_ready;
    found = 1'b0;
    g     = 0;
    for (int off = 0; off < N; off++) begin
      k = (m_ptr + off) % N;
      if (!found && bus.req_valid[k]) begin
        found = 1'b1;
        g     = k;
      end
    end
    exp_rdy = (slot && found) ? 2'(1 << g) : 2'b00;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_id", 32'(bus.rsp_id), m_id);
      check("rsp_prod", 32'(bus.rsp_prod), 32'(m_prod));
    end
    check("op_count", 32'(op_count), m_cnt);
    n_valid = m_valid;
    n_prod  = m_prod;
    n_id    = m_id;
    n_ptr   = m_ptr;
    n_cnt   = m_cnt;
    if (m_valid && bus.rsp_ready && m_cnt < 65535) n_cnt = m_cnt + 1;
    if (slot && found) begin
      n_valid = 1'b1;
      n_prod  = ref_prod(bus.req_a[g*W +: W], bus.req_b[g*W +: W],
                         int'(bus.req_h[g*HW +: HW]), int'(bus.req_v[g*VW +: VW]));
      n_id    = g;
      n_ptr   = (g + 1) % N;
    end else if (bus.rsp_ready) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid;
    m_prod  = n_prod;
    m_id    = n_id;
    m_ptr   = n_ptr;
    m_cnt   = n_cnt;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int  done;
    bit  s_acc;

    tv[0] = '{0, 8'd200, 8'd150, 4'd0,  5'd0,  16'd30000};
    tv[1] = '{1, 8'hFF,  8'hFF,  4'd7,  5'd8,  16'd32512};
    tv[2] = '{0, 8'd3,   8'd5,   4'd2,  5'd0,  16'd12};
    tv[3] = '{1, 8'hAB,  8'hCD,  4'd9,  5'd0,  16'd0};
    tv[4] = '{0, 8'hFF,  8'hFF,  4'd8,  5'd0,  16'd0};
    tv[5] = '{1, 8'hFF,  8'hFF,  4'd0,  5'd14, 16'd16384};
    tv[6] = '{0, 8'hFF,  8'hFF,  4'd0,  5'd15, 16'd0};
    tv[7] = '{1, 8'hFF,  8'hFF,  4'd15, 5'd31, 16'd0};
    tv[8] = '{1, 8'd12,  8'd10,  4'd0,  5'd0,  16'd120};

    bus.req_valid   = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_h       = '0;
    bus.req_v       = '0;
    bus.rsp_ready   = 1'b1;
    bus_s.req_valid = '0;
    bus_s.req_a     = '0;
    bus_s.req_b     = '0;
    bus_s.req_h     = '0;
    bus_s.req_v     = '0;
    bus_s.rsp_ready = 1'b1;

    reset_pulse();
    check("reset_valid", 32'(bus.rsp_valid), 0);
    check("reset_prod",  32'(bus.rsp_prod), 0);
    check("reset_id",    32'(bus.rsp_id), 0);
    check("reset_count", 32'(op_count), 0);

    // Directed vector table: one request, result next cycle, then consumed.
    for (int i = 0; i < 9; i++) begin
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      set_req(tv[i].id, 1'b1, tv[i].a, tv[i].b, tv[i].h, tv[i].v);
      step();
      check("tv_valid", 32'(bus.rsp_valid), 1);
      check("tv_id",    32'(bus.rsp_id), tv[i].id);
      check("tv_prod",  32'(bus.rsp_prod), 32'(tv[i].exp));
      bus.req_valid = '0;
      step();
      if (i == 0) check("first_count", 32'(op_count), 1);
    end

    // Contention: both valid, full throughput, alternating grants from ptr=0.
    reset_pulse();
    set_req(0, 1'b1, 8'd3, 8'd4, 4'd0, 5'd0);
    set_req(1, 1'b1, 8'd5, 8'd6, 4'd0, 5'd0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_valid", 32'(bus.rsp_valid), 1);
      check("rr_id",    32'(bus.rsp_id), i % 2);
      check("rr_prod",  32'(bus.rsp_prod), (i % 2) ? 30 : 12);
    end

    // Backpressure: result from requester 1 held three cycles.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_id",    32'(bus.rsp_id), 1);
      check("hold_prod",  32'(bus.rsp_prod), 30);
      check("hold_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    check("release_id",   32'(bus.rsp_id), 0);
    check("release_prod", 32'(bus.rsp_prod), 12);

    // Asynchronous reset while a result is held and five ops have completed.
    reset_pulse();
    bus.req_valid = '0;
    set_req(0, 1'b1, 8'd3, 8'd4, 4'd0, 5'd0);
    bus.rsp_ready = 1'b1;
    repeat (6) step();
    check("pre_rst_count", 32'(op_count), 5);
    check("pre_rst_valid", 32'(bus.rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.rsp_valid), 0);
    check("async_prod",  32'(bus.rsp_prod), 0);
    check("async_count", 32'(op_count), 0);
    check("async_id",    32'(bus.rsp_id), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1, 1'b1, 8'd5, 8'd6, 4'd0, 5'd0);
    step();
    check("post_rst_id", 32'(bus.rsp_id), 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++)
        set_req(k, ($urandom % 3) != 0, 8'($urandom), 8'($urandom),
                4'($urandom_range(0, 9)), 5'($urandom_range(0, 17)));
      bus.rsp_ready = ($urandom % 4) != 0;
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    step();

    // Saturation on the CNT_W=4 instance: 20 completions must stop at 15.
    done  = 0;
    s_acc = 1'b0;
    for (int c = 0; c < 22; c++) begin
      bus_s.req_valid = (c < 20) ? 2'b01 : 2'b00;
      @(negedge clk);
      check("sat_count", 32'(op_count_s), (done > 15) ? 15 : done);
      @(posedge clk);
      #1;
      if (s_acc) done++;
      s_acc = (c < 20);
    end
    check("sat_final", 32'(op_count_s), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bam_mult_scheduler.md
Name: bam_mult_scheduler

Overview:
- Shares one runtime-configurable 8x8 unsigned broken-array multiplier (BAM) datapath between N_REQ requesters.
- Each request carries its own horizontal and vertical break levels.
- Round-robin arbiter selects one request per cycle; the BAM product is computed combinationally and captured in a single-entry output register with a valid/ready handshake.
- Sits between accelerator lanes and the approximate-multiplier resource; lets lanes trade accuracy per operation without separate multiplier instances.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- W, 8, operand width; product width is 2W.
- HW, 4, width of the horizontal break level field (must hold 0..W+1).
- VW, 5, width of the vertical break level field (must hold 0..2W).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*W  operand a, requester k at slice [k*W +: W].
- req_b  in  N_REQ*W  operand b, same packing.
- req_h  in  N_REQ*HW  horizontal break level, same packing.
- req_v  in  N_REQ*VW  vertical break level, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumed.
- rsp_id  out  clog2(N_REQ) (min 1)  index of the requester that owns the result.
- rsp_prod  out  2W  approximate product.
- op_count  out  CNT_W  saturating count of completed responses.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rsp_valid=0, rsp_id=0, rsp_prod=0, op_count=0, RR pointer ptr=0. Assertion at any time aborts any held result, which is lost.
- Product rule: rsp_prod = sum of (a[i]&b[j])<<(i+j) over all i,j in 0..W-1 with j>=h and i+j>=v.
  - Summation is exact (no carry truncation).
  - h=0,v=0 gives the exact product.
  - h>=W or v>=2W-1 with no surviving terms gives 0.
  - h/v values above range are legal and act as "drop all".
- slot_free = !rsp_valid || rsp_ready.
- Arbitration (combinational): grant = first k with req_valid[k], scanning ptr, ptr+1, ... mod N_REQ.
  - req_ready[k] = slot_free && grant==k.
  - No valid requests means all req_ready=0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs when req_valid[k]&&req_ready[k]. On that edge:
  - rsp_prod and rsp_id are loaded from the granted requester.
  - rsp_valid=1.
  - ptr=(k+1) mod N_REQ.
  - Latency is 1 cycle: the result is visible the cycle after acceptance.
- Response hold: while rsp_valid && !rsp_ready, rsp_prod and rsp_id are stable, all req_ready=0, and ptr is unchanged.
- Simultaneous consume and accept: if rsp_ready is high while rsp_valid is high and a new transfer occurs in the same cycle, the register reloads with rsp_valid staying 1. This gives full throughput of 1 op/cycle.
- Consume without new request: rsp_valid falls to 0.
- op_count increments on each rsp_valid&&rsp_ready and saturates at 2^CNT_W-1.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,N_REQ-1. No requester waits more than N_REQ-1 grants.
- Requester inputs are sampled only in the accepting cycle. Changes to operands or levels while waiting are allowed and take effect at acceptance.

Test Plan:
- Exact mode: requester 0 sends a=200, b=150, h=0, v=0, rsp_ready=1. Required: req_ready[0]=1 the same cycle; next cycle rsp_valid=1, rsp_prod=30000, rsp_id=0; op_count=1 after consume.
- Break levels h=7, v=8: a=0xFF, b=0xFF gives 0x7F00 (32512). h=2, v=0, a=3, b=5 gives 12. h=9, v=0, any operands, gives 0.
- Contention: both requesters valid for 6 cycles, rsp_ready=1, ptr=0 after reset. Required: rsp_id sequence 0,1,0,1,0,1, one result per cycle, never both req_ready high.
- Backpressure: a result is held while rsp_ready=0 for 3 cycles with both requesters valid. Required: rsp_prod and rsp_id stable; req_ready=00; ptr unchanged; on release, the next grant goes to the requester after the held one.
- Reset mid-operation: assert rst_n=0 asynchronously mid-cycle while rsp_valid=1 and op_count=5. Required: rsp_valid, rsp_prod and op_count drop to 0 immediately, before the next clock edge; the first grant after release goes to requester 0.
- Counter saturation: with CNT_W=4, complete 20 transactions. Required: op_count stops at 15.
